// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional feature macro used elsewhere in this slice: FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Increment an index and wrap it back to 0 at n (n need not be a power of 2).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side bus of the FIFO write arbiter: requests, beats, full flag and
// the arbiter's grant/write outputs. beat_cnt exists only with FIFO_ARB_STATS_EN.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            gnt;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         din;
  logic                          locked;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*CNT_WIDTH-1:0]  beat_cnt;

  modport master (output req, req_data, full, input gnt, w_en, din, locked, beat_cnt);
  modport slave  (input req, req_data, full, output gnt, w_en, din, locked, beat_cnt);
`else
  modport master (output req, req_data, full, input gnt, w_en, din, locked);
  modport slave  (input req, req_data, full, output gnt, w_en, din, locked);
`endif
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first asserted request scanning from rr_ptr
// upward, wrapping modulo N.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  logic [PW-1:0] scan_idx;
  int            scan_pos;

  // Walk the requesters starting at rr_ptr; the first hit wins.
  always_comb begin
    win_oh   = '0;
    win_idx  = '0;
    any      = 1'b0;
    scan_pos = 0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_pos = int'(rr_ptr) + k;
      if (scan_pos >= N) scan_pos = scan_pos - N;
      scan_idx = PW'(scan_pos);
      if (!any && req[scan_idx]) begin
        any              = 1'b1;
        win_oh[scan_idx] = 1'b1;
        win_idx          = scan_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the FIFO write port with bounded burst locking.
// Optional per-requester accepted-beat counters: define FIFO_ARB_STATS_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic                 wclk,
  input logic                 wrst_n,
  fifo_write_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    st, st_n;
  logic [PW-1:0] rr_ptr, rr_ptr_n;
  logic [PW-1:0] owner, owner_n;
  logic [BW-1:0] beat, beat_n;

  logic [NUM_REQ-1:0] pick_oh;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] gnt_c;
  logic [DATA_WIDTH-1:0] din_c;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // State register; reset abandons any burst in progress.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      st     <= ARB_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      beat   <= '0;
    end else begin
      st     <= st_n;
      rr_ptr <= rr_ptr_n;
      owner  <= owner_n;
      beat   <= beat_n;
    end
  end

  // Next-state: pick a new owner in IDLE, count or release the burst in BURST.
  always_comb begin
    st_n     = st;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    beat_n   = beat;
    case (st)
      ARB_IDLE: begin
        if (pick_any && !bus.full) begin
          if (MAX_BURST == 1) begin
            rr_ptr_n = PW'(wrap_inc(32'(pick_idx), NUM_REQ));
          end else begin
            st_n    = ARB_BURST;
            owner_n = pick_idx;
            beat_n  = BW'(1);
          end
        end
      end
      ARB_BURST: begin
        // A dropped request costs one bubble and ends the burst; full only stalls it.
        if (!bus.req[owner] || (!bus.full && beat == BW'(MAX_BURST - 1))) begin
          st_n     = ARB_IDLE;
          rr_ptr_n = PW'(wrap_inc(32'(owner), NUM_REQ));
          beat_n   = '0;
        end else if (!bus.full) begin
          beat_n = beat + BW'(1);
        end
      end
      default: st_n = ARB_IDLE;
    endcase
  end

  // Outputs: zero-latency grant and data mux, forced quiet during reset.
  always_comb begin
    gnt_c = '0;
    din_c = '0;
    if (wrst_n) begin
      case (st)
        ARB_IDLE:  if (pick_any && !bus.full) gnt_c = pick_oh;
        ARB_BURST: if (bus.req[owner] && !bus.full) gnt_c[owner] = 1'b1;
        default:   gnt_c = '0;
      endcase
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) din_c = din_c | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.w_en   = |gnt_c;
  assign bus.din    = din_c;
  assign bus.locked = wrst_n && (st == ARB_BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    // Saturating count of beats accepted from requester g.
    always_ff @(posedge wclk) begin
      if (!wrst_n) begin
        cnt_q[g] <= '0;
      end else if (gnt_c[g] && (cnt_q[g] != '1)) begin
        cnt_q[g] <= cnt_q[g] + CNT_WIDTH'(1);
      end
    end
    assign bus.beat_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench: one arbiter without burst locking and one with MAX_BURST=4,
// driven on the falling edge and checked 1 ns later.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 4;

  logic wclk = 1'b0;
  logic wrst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 wclk = ~wclk;

  fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) if1 ();
  fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) if4 ();

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1), .CNT_WIDTH(CW)) u_b1 (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (if1)
  );

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(CW)) u_b4 (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (if4)
  );

  function automatic logic [7:0] dat1(input int i, input int c);
    return 8'(((c % 16) * 16) + i);
  endfunction

  function automatic logic [7:0] dat4(input int i, input int c);
    return dat1(i, c) ^ 8'h80;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] r1, input logic [3:0] r4, input logic f);
    @(negedge wclk);
    cyc++;
    wrst_n   = rst;
    if1.req  = r1;
    if4.req  = r4;
    if1.full = f;
    if4.full = f;
    for (int i = 0; i < NR; i++) begin
      if1.req_data[i*DW +: DW] = dat1(i, cyc);
      if4.req_data[i*DW +: DW] = dat4(i, cyc);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] g, input logic l, input logic [7:0] d);
    chk({tag, "_gnt"}, 32'(if4.gnt), 32'(g));
    chk({tag, "_wen"}, 32'(if4.w_en), 32'(|g));
    chk({tag, "_locked"}, 32'(if4.locked), 32'(l));
    chk({tag, "_din"}, 32'(if4.din), 32'(d));
  endtask

  logic [3:0] e_g3 [9] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1};
  logic       e_l3 [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  int         e_i3 [9] = '{0, 0, 0, 0, 2, 2, 2, 2, 0};

  // Linear directed sequence.
  initial begin
    wrst_n       = 1'b0;
    if1.req      = '0;
    if4.req      = '0;
    if1.full     = 1'b0;
    if4.full     = 1'b0;
    if1.req_data = '0;
    if4.req_data = '0;

    // Reset with all requests up: everything quiet.
    drive(1'b0, 4'hF, 4'hF, 1'b0);
    chk("rst_gnt1", 32'(if1.gnt), 32'h0);
    chk("rst_wen1", 32'(if1.w_en), 32'h0);
    chk("rst_din1", 32'(if1.din), 32'h0);
    chk("rst_locked1", 32'(if1.locked), 32'h0);
    chk4("rst4", 4'h0, 1'b0, 8'h00);
    drive(1'b0, 4'hF, 4'hF, 1'b0);

    // MAX_BURST=1 rotation 0001,0010,0100,1000,0001.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'hF, 4'h0, 1'b0);
      chk("rr1_gnt", 32'(if1.gnt), 32'(4'h1 << (k % 4)));
      chk("rr1_din", 32'(if1.din), 32'(dat1(k % 4, cyc)));
      chk("rr1_wen", 32'(if1.w_en), 32'h1);
      chk("rr1_locked", 32'(if1.locked), 32'h0);
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // MAX_BURST=4, req 0101: four beats of 0, four of 2, then 0 again.
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 4'h0, 4'h5, 1'b0);
      chk4("burst", e_g3[k], e_l3[k], dat4(e_i3[k], cyc));
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // Owner 1 stalled by full after two beats, then finishes exactly two more.
    drive(1'b1, 4'h0, 4'h2, 1'b0);
    chk4("stall_b1", 4'h2, 1'b0, dat4(1, cyc));
    drive(1'b1, 4'h0, 4'h2, 1'b0);
    chk4("stall_b2", 4'h2, 1'b1, dat4(1, cyc));
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'h0, 4'hF, 1'b1);
      chk4("stall_full", 4'h0, 1'b1, 8'h00);
    end
    drive(1'b1, 4'h0, 4'hF, 1'b0);
    chk4("stall_b3", 4'h2, 1'b1, dat4(1, cyc));
    drive(1'b1, 4'h0, 4'hF, 1'b0);
    chk4("stall_b4", 4'h2, 1'b1, dat4(1, cyc));
    drive(1'b1, 4'h0, 4'hF, 1'b0);
    chk4("stall_next", 4'h4, 1'b0, dat4(2, cyc));
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // Full in IDLE blocks; owner 0 drops after one beat -> bubble, then 3 via rr_ptr=1.
    drive(1'b1, 4'h0, 4'h1, 1'b1);
    chk4("idle_full", 4'h0, 1'b0, 8'h00);
    drive(1'b1, 4'h0, 4'h1, 1'b0);
    chk4("drop_b1", 4'h1, 1'b0, dat4(0, cyc));
    drive(1'b1, 4'h0, 4'h8, 1'b0);
    chk4("drop_bubble", 4'h0, 1'b1, 8'h00);
    drive(1'b1, 4'h0, 4'h8, 1'b0);
    chk4("drop_next", 4'h8, 1'b0, dat4(3, cyc));

`ifdef FIFO_ARB_STATS_EN
    // Counter saturation and clear.
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    chk("cnt_clr4", 32'(if4.beat_cnt), 32'h0);
    chk("cnt_clr1", 32'(if1.beat_cnt), 32'h0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 4'h0, 4'h4, 1'b0);
      chk("cnt_gnt", 32'(if4.gnt), 32'h4);
    end
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    chk("cnt_sat", 32'(if4.beat_cnt), 32'h0F00);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    chk("cnt_rst", 32'(if4.beat_cnt), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
